// File: rtl/cic_decimator.sv
// N-stage CIC decimator: registered integrator cascade, runtime ratio/shift latched
// per frame, pipelined comb section and saturating normalised output.

module cic_comb_stage #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] dly;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      dly  <= '0;
    end else if (vld) begin
      dout <= din - dly;
      dly  <= din;
    end
  end
endmodule

module cic_decimator #(
  parameter int N_STAGES   = 5,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int R_MAX_LOG2 = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [15:0]          decim_r,
  input  logic [6:0]           out_shift,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid
);
  localparam int ACC_WIDTH = IN_WIDTH + N_STAGES * R_MAX_LOG2;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [N_STAGES:1][ACC_WIDTH-1:0] integ, integ_nxt;
  logic [N_STAGES:0][ACC_WIDTH-1:0] comb;
  logic [N_STAGES:0]                vld_pipe;
  logic [N_STAGES:0][6:0]           sh_pipe;
  logic [ACC_WIDTH-1:0]             dec_reg;
  logic [ACC_WIDTH-1:0]             in_sext;

  logic [15:0] cnt, r_eff, r_in, r_cur;
  logic [6:0]  sh_eff, sh_cur;
  logic        frame_start, strobe;

  assign in_sext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

  // Each stage adds the previous stage's old value, so int[N] lags the input by N-1 samples.
  always_comb begin
    integ_nxt    = integ;
    integ_nxt[1] = integ[1] + in_sext;
    for (int k = 2; k <= N_STAGES; k++) integ_nxt[k] = integ[k] + integ[k-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) integ <= '0;
    else if (in_valid) integ <= integ_nxt;
  end

  // The ratio/shift in force for a frame come straight from the inputs on its first sample.
  assign r_in        = (decim_r < 16'd2) ? 16'd1 : decim_r;
  assign frame_start = (cnt == 16'd0);
  assign r_cur       = frame_start ? r_in : r_eff;
  assign sh_cur      = frame_start ? out_shift : sh_eff;
  assign strobe      = in_valid && (cnt == r_cur - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      r_eff  <= 16'd1;
      sh_eff <= '0;
    end else if (in_valid) begin
      if (frame_start) begin
        r_eff  <= r_in;
        sh_eff <= out_shift;
      end
      cnt <= strobe ? 16'd0 : cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_reg  <= '0;
      vld_pipe <= '0;
      sh_pipe  <= '0;
    end else begin
      vld_pipe[0] <= strobe;
      if (strobe) begin
        dec_reg    <= integ_nxt[N_STAGES];
        sh_pipe[0] <= sh_cur;
      end
      for (int k = 1; k <= N_STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) sh_pipe[k] <= sh_pipe[k-1];
      end
    end
  end

  assign comb[0] = dec_reg;

  for (genvar k = 1; k <= N_STAGES; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_WIDTH)) u_comb (
      .clk  (clk),
      .rst  (rst),
      .vld  (vld_pipe[k-1]),
      .din  (comb[k-1]),
      .dout (comb[k])
    );
  end

  logic signed [ACC_WIDTH-1:0]    y_sh;
  logic [ACC_WIDTH-OUT_WIDTH:0]   y_hi;
  logic [OUT_WIDTH-1:0]           y_sat;

  assign y_sh = $signed(comb[N_STAGES]) >>> sh_pipe[N_STAGES];
  assign y_hi = y_sh[ACC_WIDTH-1:OUT_WIDTH-1];

  // In range iff every bit from the output sign bit upward agrees.
  always_comb begin
    y_sat = y_sh[OUT_WIDTH-1:0];
    if (!((&y_hi) || !(|y_hi))) y_sat = y_sh[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_pipe[N_STAGES];
      if (vld_pipe[N_STAGES]) out_data <= y_sat;
    end
  end
endmodule
